// File: rtl/hilo_muldiv_if.sv
// Handshake and result bundle between the EX stage and the HI/LO multiply/divide sequencer.
//   master : EX-stage side, drives flush/hold/start/op/operands and receives stall, status and results
//   slave  : sequencer side
// Signals:
//   flush_i          cancel any operation in flight
//   hold_i           downstream stall, result must be held
//   start_i          issue an operation this cycle
//   op_i             00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a_i      rs (multiplicand / dividend)
//   operand_b_i      rt (multiplier / divisor)
//   stall_o          pipeline stall request
//   busy_o           sequencer not idle
//   done_o           result valid on hi_o/lo_o
//   hilo_write_en_o  one-cycle HI/LO write strobe
//   hi_o, lo_o       HI/LO results
interface hilo_muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush_i;
  logic                  hold_i;
  logic                  start_i;
  logic [1:0]            op_i;
  logic [DATA_WIDTH-1:0] operand_a_i;
  logic [DATA_WIDTH-1:0] operand_b_i;
  logic                  stall_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  hilo_write_en_o;
  logic [DATA_WIDTH-1:0] hi_o;
  logic [DATA_WIDTH-1:0] lo_o;

  modport master (
    output flush_i, hold_i, start_i, op_i, operand_a_i, operand_b_i,
    input  stall_o, busy_o, done_o, hilo_write_en_o, hi_o, lo_o
  );

  modport slave (
    input  flush_i, hold_i, start_i, op_i, operand_a_i, operand_b_i,
    output stall_o, busy_o, done_o, hilo_write_en_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer producing HI/LO for MULT, MULTU, DIV, DIVU.
// One operation at a time; the pipeline is stalled while iterating, and a single
// HI/LO write strobe is issued per completed operation.
// Iterative shift-add multiplier and radix-2 restoring divider share one 2*DATA_WIDTH
// working register. Signed operations run on magnitudes; signs are fixed on entry to DONE.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  hilo_muldiv_if.slave (operation request, stall/status, HI/LO result)
// Build option:
//   HILO_MULDIV_FAST_MUL_EN  defined: MULT/MULTU use a single-cycle multiplier and go
//                            straight to DONE; no MUL state. Undefined: iterative multiplier.
module hilo_muldiv_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ITER_CNT_W = 6
) (
  input logic            clk,
  input logic            rst,
  hilo_muldiv_if.slave   bus
);

  localparam int W = DATA_WIDTH;
  localparam logic [ITER_CNT_W-1:0] CNT_LAST = ITER_CNT_W'(DATA_WIDTH);

`ifdef HILO_MULDIV_FAST_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`endif

  function automatic logic [W-1:0] neg_sw(input logic [W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*W-1:0] neg_dw(input logic [2*W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_t                state, state_n;
  logic [ITER_CNT_W-1:0] cnt, cnt_n;
  logic [2*W-1:0]        acc, acc_n;
  logic [W-1:0]          opnd, opnd_n;
  logic                  neg_q, neg_q_n;
  logic                  neg_r, neg_r_n;
  logic [W-1:0]          hi_q, hi_n, lo_q, lo_n;

  logic                  start_ok, launch, is_signed, iterating;
  logic                  neg_q_in, neg_r_in;
  logic [W-1:0]          mag_a, mag_b;
  logic [ITER_CNT_W-1:0] cnt_inc;
  logic [W:0]            rem_sh;
  logic                  rem_ge;
  logic [W-1:0]          rem_new;
  logic [2*W-1:0]        acc_div;

  assign start_ok  = bus.start_i & ~bus.flush_i;
  assign is_signed = ~bus.op_i[0];
  assign neg_q_in  = is_signed & (bus.operand_a_i[W-1] ^ bus.operand_b_i[W-1]);
  assign neg_r_in  = is_signed & bus.operand_a_i[W-1];
  assign mag_a     = neg_sw(bus.operand_a_i, neg_r_in);
  assign mag_b     = neg_sw(bus.operand_b_i, is_signed & bus.operand_b_i[W-1]);
  assign cnt_inc   = cnt + 1'b1;

  // Restoring divide step: acc = {partial remainder, dividend/quotient shift}
  assign rem_sh  = acc[2*W-1:W-1];
  assign rem_ge  = rem_sh >= {1'b0, opnd};
  assign rem_new = rem_ge ? W'(rem_sh - {1'b0, opnd}) : rem_sh[W-1:0];
  assign acc_div = {rem_new, acc[W-2:0], rem_ge};

`ifdef HILO_MULDIV_FAST_MUL_EN
  logic [2*W-1:0] prod;
  assign prod      = (2*W)'(mag_a) * (2*W)'(mag_b);
  assign iterating = (state == S_DIV);
`else
  // Shift-add multiply step: acc = {partial product high, multiplier bits still to consume}
  logic [W:0]     mul_sum;
  logic [2*W-1:0] acc_mul;
  assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
  assign acc_mul   = {mul_sum, acc[W-1:1]};
  assign iterating = (state == S_DIV) | (state == S_MUL);
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    opnd_n  = opnd;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    hi_n    = hi_q;
    lo_n    = lo_q;
    launch  = 1'b0;

    case (state)
      S_IDLE: launch = 1'b1;
`ifndef HILO_MULDIV_FAST_MUL_EN
      S_MUL: begin
        acc_n = acc_mul;
        cnt_n = cnt_inc;
        if (cnt_inc == CNT_LAST) begin
          {hi_n, lo_n} = neg_dw(acc_mul, neg_q);
          state_n      = S_DONE;
        end
      end
`endif
      S_DIV: begin
        acc_n = acc_div;
        cnt_n = cnt_inc;
        if (cnt_inc == CNT_LAST) begin
          hi_n    = neg_sw(acc_div[2*W-1:W], neg_r);
          lo_n    = neg_sw(acc_div[W-1:0], neg_q);
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        // Result is held while downstream stalls; a start is only taken once it is written.
        if (!bus.hold_i) begin
          state_n = S_IDLE;
          launch  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (launch && start_ok) begin
      cnt_n = '0;
      if (!bus.op_i[1]) begin
`ifdef HILO_MULDIV_FAST_MUL_EN
        {hi_n, lo_n} = neg_dw(prod, neg_q_in);
        state_n      = S_DONE;
`else
        acc_n   = {{W{1'b0}}, mag_b};
        opnd_n  = mag_a;
        neg_q_n = neg_q_in;
        state_n = S_MUL;
`endif
      end else if (bus.operand_b_i == '0) begin
        // Divide by zero: no trap, dividend passes through to HI, LO all ones.
        hi_n    = bus.operand_a_i;
        lo_n    = '1;
        state_n = S_DONE;
      end else begin
        acc_n   = {{W{1'b0}}, mag_a};
        opnd_n  = mag_b;
        neg_q_n = neg_q_in;
        neg_r_n = neg_r_in;
        state_n = S_DIV;
      end
    end

    if (bus.flush_i) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      acc   <= acc_n;
      opnd  <= opnd_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  assign bus.stall_o         = iterating | (((state == S_IDLE) | (state == S_DONE)) & start_ok);
  assign bus.busy_o          = (state != S_IDLE);
  assign bus.done_o          = (state == S_DONE);
  assign bus.hilo_write_en_o = (state == S_DONE) & ~bus.hold_i & ~bus.flush_i;
  assign bus.hi_o            = hi_q;
  assign bus.lo_o            = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Testbench for hilo_muldiv_ctrl: directed operations with literal expected HI/LO values,
// plus a cycle-level reference model built from plain 64-bit arithmetic and operation
// latencies, compared against every DUT output on each falling edge.
module tb_hilo_muldiv_ctrl;

  localparam int W = 32;
`ifdef HILO_MULDIV_FAST_MUL_EN
  localparam int MUL_EDGES = 0;
`else
  localparam int MUL_EDGES = W;
`endif
  localparam int MUL_STALL = MUL_EDGES + 1;
  localparam int DIV_STALL = W + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.DATA_WIDTH(W)) bus ();

  hilo_muldiv_ctrl #(.DATA_WIDTH(W), .ITER_CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int st_cnt = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  task automatic chk_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference results straight from integer arithmetic.
  function automatic void model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; p = q; lo = p[31:0]; p = r; hi = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  // Cycle model: an accepted op completes a fixed number of edges later and is then held
  // until it can be written.
  bit          m_valid = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_left  = 0;
    end else if (bus.flush_i) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_hi   = p_hi;
        m_lo   = p_lo;
      end
    end else if (!(m_done && bus.hold_i)) begin
      m_done = 1'b0;
      if (bus.start_i) begin
        model_res(bus.op_i, bus.operand_a_i, bus.operand_b_i, p_hi, p_lo);
        if (!bus.op_i[1]) m_left = MUL_EDGES;
        else m_left = (bus.operand_b_i == 32'd0) ? 0 : W;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_hi   = p_hi;
          m_lo   = p_lo;
        end else begin
          m_busy = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk_bit("busy", bus.busy_o, m_busy || m_done);
      chk_bit("done", bus.done_o, m_done);
      chk_bit("stall", bus.stall_o, m_busy || (bus.start_i && !bus.flush_i));
      chk_bit("hilo_we", bus.hilo_write_en_o, m_done && !bus.hold_i && !bus.flush_i);
      if (m_done) begin
        chk_word("model_hi", bus.hi_o, m_hi);
        chk_word("model_lo", bus.lo_o, m_lo);
      end
      if (bus.stall_o === 1'b1) st_cnt++;
      if (bus.hilo_write_en_o === 1'b1) we_cnt++;
      if (bus.done_o === 1'b1) done_cnt++;
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.done_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk_bit({name, "_done_seen"}, bus.done_o, 1'b1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i     = 1'b1;
    bus.op_i        = op;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  // Called at posedge+1 with the sequencer idle and hold_i low.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int est);
    st_cnt = 0;
    we_cnt = 0;
    issue(op, a, b);
    wait_done(name);
    chk_word({name, "_hi"}, bus.hi_o, ehi);
    chk_word({name, "_lo"}, bus.lo_o, elo);
    @(posedge clk); #1;
    chk_word({name, "_stall_cycles"}, st_cnt, est);
    chk_word({name, "_writes"}, we_cnt, 32'd1);
    chk_bit({name, "_idle_after"}, bus.busy_o, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    bus.flush_i     = 1'b0;
    bus.hold_i      = 1'b0;
    bus.start_i     = 1'b0;
    bus.op_i        = 2'b00;
    bus.operand_a_i = '0;
    bus.operand_b_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk_bit("rst_busy", bus.busy_o, 1'b0);
    chk_bit("rst_done", bus.done_o, 1'b0);
    chk_bit("rst_stall", bus.stall_o, 1'b0);
    chk_bit("rst_we", bus.hilo_write_en_o, 1'b0);
    chk_word("rst_hi", bus.hi_o, 32'h0);
    chk_word("rst_lo", bus.lo_o, 32'h0);

    run_op("mult_neg1x2",  2'b00, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALL);
    run_op("multu_maxx2",  2'b01, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE, MUL_STALL);
    run_op("div_m7_2",     2'b10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_STALL);
    run_op("divu_100_7",   2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, DIV_STALL);
    run_op("divu_by_zero", 2'b11, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF, 1);
    run_op("div_by_zero",  2'b10, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
    run_op("mult_minsq",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_STALL);
    run_op("div_min_m1",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_STALL);
    run_op("mult_m3x5",    2'b00, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_STALL);
    run_op("div_7_m2",     2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_STALL);
    run_op("divu_max_1",   2'b11, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 32'hFFFF_FFFF, DIV_STALL);

    // Flush part-way through a divide.
    we_cnt = 0;
    issue(2'b10, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    chk_bit("flush_busy", bus.busy_o, 1'b0);
    chk_bit("flush_stall", bus.stall_o, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk_word("flush_writes", we_cnt, 32'd0);
    run_op("multu_3x5", 2'b01, 32'd3, 32'd5, 32'h0, 32'd15, MUL_STALL);

    // Start in the same cycle as a flush is dropped.
    bus.flush_i = 1'b1;
    issue(2'b01, 32'd9, 32'd9);
    bus.flush_i = 1'b0;
    chk_bit("flush_start_busy", bus.busy_o, 1'b0);

    // Result held by hold_i for three cycles, written in the fourth, with a back-to-back start.
    bus.hold_i = 1'b1;
    done_cnt = 0;
    we_cnt = 0;
    issue(2'b11, 32'd100, 32'd7);
    wait_done("hold_divu");
    repeat (3) begin @(posedge clk); #1; end
    chk_word("hold_hi", bus.hi_o, 32'd2);
    chk_word("hold_lo", bus.lo_o, 32'd14);
    bus.hold_i = 1'b0;
    issue(2'b01, 32'd6, 32'd7);
    chk_word("hold_done_cycles", done_cnt, 32'd4);
    chk_word("hold_writes", we_cnt, 32'd1);
    chk_bit("b2b_busy", bus.busy_o, 1'b1);
    we_cnt = 0;
    wait_done("b2b_multu");
    chk_word("b2b_hi", bus.hi_o, 32'd0);
    chk_word("b2b_lo", bus.lo_o, 32'd42);
    @(posedge clk); #1;
    chk_word("b2b_writes", we_cnt, 32'd1);

    // Reset mid-operation abandons the op and clears the results.
    we_cnt = 0;
    issue(2'b00, 32'd7, 32'd9);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_bit("rst_mid_busy", bus.busy_o, 1'b0);
    chk_word("rst_mid_hi", bus.hi_o, 32'h0);
    chk_word("rst_mid_lo", bus.lo_o, 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    chk_word("rst_mid_writes", we_cnt, 32'd0);

    run_op("div_after_rst", 2'b10, 32'd1000, 32'd3, 32'd1, 32'd333, DIV_STALL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that produces the HI/LO results of MULT, MULTU, DIV and DIVU.
- Sits beside the EX stage and accepts one operation at a time.
- Stalls the pipeline while it iterates.
- Presents a one-cycle HI/LO write that travels down to the HILO register file and its read-forwarding path.
- Contains an iterative shift-add multiplier and a radix-2 restoring divider, both sharing one 64-bit working register.

Parameters:
DATA_WIDTH, 32, operand/result width; must equal the DATA_BUS width.
ITER_CNT_W, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush_i  input  1  exception/branch cancel; kills any operation in flight
hold_i  input  1  downstream stall; result must be held while high
start_i  input  1  EX stage issues an operation this cycle
op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_a_i  input  DATA_WIDTH  rs value (multiplicand / dividend)
operand_b_i  input  DATA_WIDTH  rt value (multiplier / divisor)
stall_o  output  1  pipeline stall request (combinational)
busy_o  output  1  state is not IDLE
done_o  output  1  result valid on hi_o/lo_o
hilo_write_en_o  output  1  HI/LO write strobe to the MEM/WB pipeline
hi_o  output  DATA_WIDTH  HI result (high product / remainder)
lo_o  output  DATA_WIDTH  LO result (low product / quotient)

Behaviour:
- Reset: state IDLE, counter 0, working regs 0; stall_o, busy_o, done_o, hilo_write_en_o = 0; hi_o, lo_o = 0.
- States:
  - IDLE -> MUL on start_i & op_i[1]==0 & !flush_i.
  - IDLE -> DIV on start_i & op_i[1]==1 & !flush_i & operand_b_i!=0.
  - IDLE -> DONE on DIV/DIVU start with operand_b_i==0.
  - MUL/DIV -> DONE after counter reaches DATA_WIDTH.
  - DONE -> IDLE when !hold_i, or accepts a new start_i that same cycle (back-to-back, same transition rules as IDLE).
- Start capture: signed ops (MULT, DIV) latch |a|, |b| plus result signs. Product sign = a[31]^b[31]. Quotient sign = a[31]^b[31]. Remainder sign = a[31]. Unsigned ops latch raw values with positive signs.
- MUL iteration: one multiplier bit per cycle, shift-add into the 64-bit accumulator, DATA_WIDTH cycles.
- DIV iteration: one quotient bit per cycle, restoring subtract, DATA_WIDTH cycles.
- On entry to DONE: apply two's-complement sign correction, then register {hi_o, lo_o}.
- Latency, start sampled at edge N: MUL/DIV results valid in cycle N+DATA_WIDTH+1 (33 for 32-bit). Divide-by-zero is valid in cycle N+1.
- Divide-by-zero result: hi_o = dividend as given, lo_o = all ones. No trap.
- stall_o = (IDLE|DONE)&start_i&!flush_i | MUL | DIV | (DONE&hold_i is not a stall source). stall_o is low in DONE unless a new start is issued.
- done_o = 1 throughout DONE. hilo_write_en_o = DONE & !hold_i & !flush_i, so exactly one strobe per operation. hi_o/lo_o are stable for all of DONE.
- flush_i in any state: next state IDLE, counter cleared. No write that cycle or later. Start in the same cycle is ignored.
- start_i while in MUL/DIV is ignored; the EX stage is stalled, so none is legal.
- rst mid-operation: abandons the operation, returns to the reset values, and no write strobe is issued.
- Unsigned arithmetic is exactly 64-bit. Signed MULT of 0x80000000*0x80000000 = 0x40000000_00000000. Signed DIV 0x80000000 / 0xFFFFFFFF yields LO = 0x80000000, HI = 0.

Optional Feature:
HILO_MULDIV_FAST_MUL_EN
- Defined: MULT/MULTU compute the full 64-bit product in one cycle with the synthesis multiplier; IDLE -> DONE directly, result valid in cycle N+1. The MUL state is not generated. The divider is unchanged.
- Undefined: the iterative multiplier described above, DATA_WIDTH+1 cycle latency.

Test Plan:
- MULT a=0xFFFFFFFF, b=0x00000002 -> DONE with hi=0xFFFFFFFF, lo=0xFFFFFFFE; stall_o high 33 cycles iterative, 1 cycle with the macro; single hilo_write_en_o pulse.
- MULTU a=0xFFFFFFFF, b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002, valid at cycle 33.
- DIVU a=0x12345678, b=0 -> next cycle done_o=1, hi=0x12345678, lo=0xFFFFFFFF, one write strobe.
- DIV started, flush_i pulsed at iteration 10 -> state IDLE next cycle, stall_o low, no hilo_write_en_o. A following MULTU 3*5 -> hi=0, lo=15.
- Result reached with hold_i high for 3 cycles -> done_o high 4 cycles, values stable, hilo_write_en_o only in the 4th. Back-to-back start in that cycle begins the next op.
